mem_rr_scheduler: RTL
=====================

Name: mem_rr_scheduler

Overview:
Round-robin scheduler that shares one single-port block RAM among NUM_REQ requesters (UART loader, ring buffer, stack interpreter). It latches one request at a time, drives the RAM port and waits the fixed RAM read latency. It then returns read data and a one-cycle done pulse to the served requester. It replaces fixed-priority sharing so no requester can starve another.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 15, RAM word-address width
DATA_W, 32, RAM data width
MEM_LATENCY, 1, cycles from RAM enable to valid mem_dataOut (1..4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
module_enable  in  1  1 = new grants allowed; 0 = finish the in-flight transaction, then grant nothing
req_enable  in  NUM_REQ  per-requester request level; held until that requester's done
req_readWrite  in  NUM_REQ  per requester: 1 = write, 0 = read
req_address  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data
req_dataOut  out  NUM_REQ*DATA_W  packed read data; a slot changes only on a completed read for that requester
req_done  out  NUM_REQ  one-cycle completion pulse per requester
mem_enable  out  1  RAM enable, high exactly one cycle per transaction
mem_readWrite  out  1  RAM write strobe (1 = write)
mem_address  out  ADDR_W  RAM address
mem_dataIn  out  DATA_W  RAM write data
mem_dataOut  in  DATA_W  RAM read data
grant  out  NUM_REQ  one-hot; the served requester, high from ISSUE through DONE
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous): state IDLE. Last-served pointer = NUM_REQ-1, so requester 0 has first priority. All outputs 0, including every req_dataOut slot.
- Reset mid-transaction: abort at once. No done pulse, and req_dataOut is cleared.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if module_enable=1 and any eligible req_enable bit is set, pick the first set bit searching upward from pointer+1, modulo NUM_REQ. Latch its index, readWrite, address and data. Go to ISSUE.
- Eligibility: in the IDLE cycle directly after DONE, the just-served requester is masked. This gives it one cycle to drop req_enable. If no other request exists, it is eligible again on the next cycle.
- ISSUE (1 cycle): mem_enable=1, and mem_readWrite/address/dataIn come from the latches. grant is set. Go to WAIT.
- WAIT (MEM_LATENCY cycles, down-counter): mem_enable=0, and mem_address/readWrite/dataIn are held. On the last WAIT cycle, a read captures mem_dataOut into the granted slot. A write leaves the slot unchanged. Go to DONE.
- DONE (1 cycle): req_done[g]=1 and the slot is valid. Update pointer = g. Go to IDLE.
- Outside ISSUE and WAIT, mem_readWrite is forced to 0. mem_address and mem_dataIn hold their last values.
- Latency: request first seen in IDLE at cycle t gives mem_enable at t+1 and done at t+2+MEM_LATENCY. Throughput is one transaction per MEM_LATENCY+3 cycles.
- Requester inputs are sampled only at grant. Later changes, including dropping req_enable, do not affect the in-flight transaction; it still completes and pulses done.
- module_enable falling mid-transaction does not abort. The transaction completes, then the block stays in IDLE.
- Simultaneous requests are resolved only by the round-robin order. Over k back-to-back grants with all requests held, each requester is served within NUM_REQ grants.
- At most one req_done bit and one grant bit are high in any cycle.

Test Plan:
- Single read (MEM_LATENCY=1): RAM[0x0010]=0xDEADBEEF; requester 1 reads 0x0010 at cycle t -> mem_enable at t+1 with address 0x0010 and readWrite 0; req_done[1] at t+3; slot 1 = 0xDEADBEEF; slots 0 and 2 stay 0.
- Write then read-back: requester 2 writes 0xCAFEF00D to 0x7FFF, then reads it -> RAM gets exactly one write strobe; slot 2 = 0xCAFEF00D; slot 2 is unchanged after the write's done.
- Fairness: all three requests held high from reset -> grant order 0,1,2,0,1,2; done pulses spaced 4 cycles apart; after requester 0 drops, order is 1,2,1,2.
- Gating: module_enable=0 with req_enable=3'b111 -> no mem_enable for 20 cycles. Drop module_enable during WAIT -> that transaction's done still pulses and no further grant follows.
- Reset mid-operation: assert reset in WAIT -> next cycle busy=0, grant=0, no req_done. After release with requests held, requester 0 is granted first.
- MEM_LATENCY=3: read from requester 0 -> WAIT lasts 3 cycles; done at t+5; captured data equals mem_dataOut on the third WAIT cycle.

Source files
------------

// File: rtl/mem_rr_scheduler_if.sv
// Requester-side and RAM-side signal bundle for the round-robin block RAM scheduler.
// The slave modport is the scheduler's view; the master modport drives requesters and the RAM.
interface mem_rr_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_enable;
  logic [NUM_REQ-1:0]        req_readWrite;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DATA_W-1:0] req_dataOut;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      mem_enable;
  logic                      mem_readWrite;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_dataIn;
  logic [DATA_W-1:0]         mem_dataOut;

  modport slave (
    input  req_enable, req_readWrite, req_address, req_data, mem_dataOut,
    output req_dataOut, req_done, grant, busy,
           mem_enable, mem_readWrite, mem_address, mem_dataIn
  );

  modport master (
    output req_enable, req_readWrite, req_address, req_data, mem_dataOut,
    input  req_dataOut, req_done, grant, busy,
           mem_enable, mem_readWrite, mem_address, mem_dataIn
  );
endinterface

// File: rtl/mem_rr_scheduler.sv
// Round-robin arbiter sharing one single-port block RAM among NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE.
module mem_rr_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              module_enable,
  mem_rr_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               justDone_q;
  logic [DATA_W-1:0]  slot_q [NUM_REQ];

  logic [ADDR_W-1:0]  reqAddr [NUM_REQ];
  logic [DATA_W-1:0]  reqData [NUM_REQ];
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] eligible;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   candIdx;
  logic               captureRead;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slots
    assign reqAddr[i] = bus.req_address[i*ADDR_W +: ADDR_W];
    assign reqData[i] = bus.req_data[i*DATA_W +: DATA_W];
    assign bus.req_dataOut[i*DATA_W +: DATA_W] = slot_q[i];
  end

  assign captureRead = (state_q == WAIT) && (cnt_q == '0) && !rw_q;

  // The requester served last is hidden for one IDLE cycle so it can drop its level.
  always_comb begin
    mask      = '0;
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    if (justDone_q) mask[ptr_q] = 1'b1;
    eligible = bus.req_enable & ~mask;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pickValid && eligible[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      justDone_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      justDone_q <= (state_q == DONE);
      if (captureRead) slot_q[gnt_q] <= bus.mem_dataOut;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (module_enable && pickValid) begin
          gnt_d   = pickIdx;
          rw_d    = bus.req_readWrite[pickIdx];
          addr_d  = reqAddr[pickIdx];
          data_d  = reqData[pickIdx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_enable    = (state_q == ISSUE);
    bus.mem_readWrite = rw_q && ((state_q == ISSUE) || (state_q == WAIT));
    bus.mem_address   = addr_q;
    bus.mem_dataIn    = data_q;
    bus.busy          = (state_q != IDLE);
    bus.grant         = '0;
    bus.req_done      = '0;
    if (state_q != IDLE) bus.grant[gnt_q]    = 1'b1;
    if (state_q == DONE) bus.req_done[gnt_q] = 1'b1;
  end
endmodule
